// File: rtl/sparhixcel_pkg.sv
// Shared types and helpers for the sparse-select sequencer.
package sparhixcel_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } sel_gen_state_t;

  // True when a select of sel_w bits can address every one of n mux inputs,
  // i.e. sel_w >= clog2(n).
  function automatic bit sel_width_ok(input int sel_w, input int n);
    return (n >= 1) && (n <= (1 << sel_w));
  endfunction

endpackage

// File: rtl/sparse_sel_gen_if.sv
// Mask-in / select-out handshake bundle for sparse_sel_gen.
// slave modport is the sequencer; master modport is whoever drives masks
// and consumes beats.
interface sparse_sel_gen_if #(
  parameter int SEL_WIDTH_MUX    = 3,
  parameter int NUMBER_INPUT_MUX = 8
);
  logic                        mask_valid_i;
  logic                        mask_ready_o;
  logic [NUMBER_INPUT_MUX-1:0] mask_i;
  logic                        sel_valid_o;
  logic                        sel_ready_i;
  logic [SEL_WIDTH_MUX-1:0]    sel_mux_o;
  logic                        sel_last_o;
  logic                        sel_zero_o;

  modport slave (
    input  mask_valid_i, mask_i, sel_ready_i,
    output mask_ready_o, sel_valid_o, sel_mux_o, sel_last_o, sel_zero_o
  );

  modport master (
    output mask_valid_i, mask_i, sel_ready_i,
    input  mask_ready_o, sel_valid_o, sel_mux_o, sel_last_o, sel_zero_o
  );
endinterface

// File: rtl/sparse_sel_gen_lsb_prio_enc.sv
// Find-first-set from bit 0 upward: index and one-hot of the lowest set bit.
// An all-zero input yields index 0 and an all-zero one-hot.
module lsb_prio_enc #(
  parameter int SEL_WIDTH_MUX    = 3,
  parameter int NUMBER_INPUT_MUX = 8
) (
  input  logic [NUMBER_INPUT_MUX-1:0] vec,
  output logic [SEL_WIDTH_MUX-1:0]    idx,
  output logic [NUMBER_INPUT_MUX-1:0] onehot
);

  // Scan upward and lock onto the first set bit.
  always_comb begin
    logic found;
    idx    = '0;
    onehot = '0;
    found  = 1'b0;
    for (int k = 0; k < NUMBER_INPUT_MUX; k++) begin
      if (!found && vec[k]) begin
        idx       = SEL_WIDTH_MUX'(k);
        onehot[k] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sparse_sel_gen.sv
// Sparse-select sequencer: takes one group mask per handshake and emits the
// index of each set bit, lowest first, one beat per cycle. An all-zero mask
// emits a single flagged beat so the downstream accumulator still closes.
// Optional feature macro: SPARSE_SEL_GEN_PREFETCH_EN -- accept the next mask
// on the last-beat edge so consecutive groups run without a bubble.
module sparse_sel_gen
  import sparhixcel_pkg::*;
#(
  parameter int SEL_WIDTH_MUX    = 3,
  parameter int NUMBER_INPUT_MUX = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  sparse_sel_gen_if.slave bus
);

  localparam bit SEL_W_OK = sel_width_ok(SEL_WIDTH_MUX, NUMBER_INPUT_MUX);

  if (!SEL_W_OK) begin : g_bad_sel_width
    $error("sparse_sel_gen: NUMBER_INPUT_MUX exceeds 2**SEL_WIDTH_MUX");
  end

  sel_gen_state_t              state;
  logic [NUMBER_INPUT_MUX-1:0] remaining;
  logic                        zero_flag;

  logic [SEL_WIDTH_MUX-1:0]    low_idx;
  logic [NUMBER_INPUT_MUX-1:0] low_onehot;
  logic                        emit;
  logic                        last;
  logic                        accept;
  logic                        xfer;

  lsb_prio_enc #(
    .SEL_WIDTH_MUX   (SEL_WIDTH_MUX),
    .NUMBER_INPUT_MUX(NUMBER_INPUT_MUX)
  ) u_enc (
    .vec   (remaining),
    .idx   (low_idx),
    .onehot(low_onehot)
  );

  // Beat outputs decode registered state through the encoder only.
  always_comb begin
    emit = (state == EMIT);
    // One set bit left means clearing it empties the mask.
    last = emit && (zero_flag ||
                    ((remaining != '0) && ((remaining & ~low_onehot) == '0)));
    bus.sel_valid_o = emit;
    bus.sel_mux_o   = (emit && !zero_flag) ? low_idx : '0;
    bus.sel_last_o  = last;
    bus.sel_zero_o  = emit && zero_flag;
`ifdef SPARSE_SEL_GEN_PREFETCH_EN
    bus.mask_ready_o = !emit || (bus.sel_ready_i && last);
`else
    bus.mask_ready_o = !emit;
`endif
    accept = bus.mask_valid_i && bus.mask_ready_o;
    xfer   = emit && bus.sel_ready_i;
  end

  // Sequencer: load a mask, peel off one set bit per transferred beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      remaining <= '0;
      zero_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            remaining <= bus.mask_i;
            zero_flag <= (bus.mask_i == '0);
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (xfer) begin
            if (last) begin
              // accept can only be true here in the prefetch build.
              if (accept) begin
                remaining <= bus.mask_i;
                zero_flag <= (bus.mask_i == '0);
              end else begin
                remaining <= '0;
                zero_flag <= 1'b0;
                state     <= IDLE;
              end
            end else begin
              remaining <= remaining & ~low_onehot;
            end
          end
        end
        default: begin
          state     <= IDLE;
          remaining <= '0;
          zero_flag <= 1'b0;
        end
      endcase
    end
  end

endmodule
